// File: rtl/wino_btdb_stream_f23_if.sv
// Row-stream bundle for the Winograd F(2x2,3x3) input transform:
// input rows from the tile fetcher, transformed rows to the multiply array.
interface wino_btdb_stream_f23_if #(
  parameter int DATA_WIDTH = 20,
  parameter int OUT_W      = DATA_WIDTH + 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [4*DATA_WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*OUT_W-1:0]      out_data;
  logic [1:0]              out_row;
  logic                    out_last;

  // Producer of input rows / consumer of output rows
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_last
  );

  // The transform block itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_last
  );
endinterface

// File: rtl/wino_btdb_stream_f23.sv
// Streaming Winograd F(2x2,3x3) input transform V = B^T*d*B.
// Each accepted row is right-multiplied by B and parked in a ping-pong bank;
// once a bank holds 4 rows it is drained one B^T row per beat.
module wino_btdb_stream_f23 #(
  parameter int DATA_WIDTH = 20,
  parameter int OUT_W      = DATA_WIDTH + 2,
  parameter int SAT        = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  wino_btdb_stream_f23_if.slave bus
);
  localparam int UW = DATA_WIDTH + 1;
  localparam int VW = DATA_WIDTH + 2;

  logic [1:0]           full_q, full_d;
  logic                 wbank_q, wbank_d;
  logic                 rbank_q, rbank_d;
  logic [1:0]           wrow_q, wrow_d;
  logic [1:0]           rrow_q, rrow_d;
  logic signed [UW-1:0] mem_q [2][4][4];

  logic                 in_fire;
  logic                 out_fire;
  logic signed [UW-1:0] a_ext [4];
  logic signed [UW-1:0] u_row [4];
  logic signed [VW-1:0] r_ext [4][4];
  logic signed [VW-1:0] v_row [4];

  assign in_fire       = bus.in_valid && !full_q[wbank_q];
  assign out_fire      = full_q[rbank_q] && bus.out_ready;
  assign bus.in_ready  = !full_q[wbank_q];
  assign bus.out_valid = full_q[rbank_q];
  assign bus.out_row   = rrow_q;
  assign bus.out_last  = (rrow_q == 2'd3);

  // Row transform d*B on the incoming row, widened by one bit
  always_comb begin
    for (int unsigned j = 0; j < 4; j++) begin
      a_ext[j] = {bus.in_data[j*DATA_WIDTH + DATA_WIDTH - 1],
                  bus.in_data[j*DATA_WIDTH +: DATA_WIDTH]};
    end
    u_row[0] = a_ext[0] - a_ext[2];
    u_row[1] = a_ext[1] + a_ext[2];
    u_row[2] = a_ext[2] - a_ext[1];
    u_row[3] = a_ext[1] - a_ext[3];
  end

  // Tile storage: no reset needed, occupancy is tracked by full_q
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int unsigned j = 0; j < 4; j++) begin
        mem_q[wbank_q][wrow_q][j] <= u_row[j];
      end
    end
  end

  // Bank/row pointer and occupancy next-state; write and drain always target different banks
  always_comb begin
    full_d  = full_q;
    wbank_d = wbank_q;
    wrow_d  = wrow_q;
    rbank_d = rbank_q;
    rrow_d  = rrow_q;
    if (in_fire) begin
      wrow_d = wrow_q + 2'd1;
      if (wrow_q == 2'd3) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = !wbank_q;
      end
    end
    if (out_fire) begin
      rrow_d = rrow_q + 2'd1;
      if (rrow_q == 2'd3) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = !rbank_q;
      end
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= '0;
      wbank_q <= 1'b0;
      wrow_q  <= '0;
      rbank_q <= 1'b0;
      rrow_q  <= '0;
    end else begin
      full_q  <= full_d;
      wbank_q <= wbank_d;
      wrow_q  <= wrow_d;
      rbank_q <= rbank_d;
      rrow_q  <= rrow_d;
    end
  end

  // Column transform B^T for the current output row, full precision
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        r_ext[k][j] = {mem_q[rbank_q][k][j][UW-1], mem_q[rbank_q][k][j]};
      end
    end
    for (int unsigned j = 0; j < 4; j++) begin
      case (rrow_q)
        2'd0:    v_row[j] = r_ext[0][j] - r_ext[2][j];
        2'd1:    v_row[j] = r_ext[1][j] + r_ext[2][j];
        2'd2:    v_row[j] = r_ext[2][j] - r_ext[1][j];
        default: v_row[j] = r_ext[1][j] - r_ext[3][j];
      endcase
    end
  end

  generate
    if (OUT_W >= VW) begin : g_ext
      // Lossless: sign-extend into the output lane
      always_comb begin
        bus.out_data = '0;
        for (int unsigned j = 0; j < 4; j++) begin
          bus.out_data[j*OUT_W +: OUT_W] = OUT_W'(v_row[j]);
        end
      end
    end else if (SAT != 0) begin : g_sat
      localparam logic signed [VW-1:0] SMAX = {{(VW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [VW-1:0] SMIN = ~SMAX;
      // Narrow output: clamp to the representable range
      always_comb begin
        bus.out_data = '0;
        for (int unsigned j = 0; j < 4; j++) begin
          if (v_row[j] > SMAX) begin
            bus.out_data[j*OUT_W +: OUT_W] = SMAX[OUT_W-1:0];
          end else if (v_row[j] < SMIN) begin
            bus.out_data[j*OUT_W +: OUT_W] = SMIN[OUT_W-1:0];
          end else begin
            bus.out_data[j*OUT_W +: OUT_W] = v_row[j][OUT_W-1:0];
          end
        end
      end
    end else begin : g_wrap
      // Narrow output: keep low bits (two's-complement wrap)
      always_comb begin
        bus.out_data = '0;
        for (int unsigned j = 0; j < 4; j++) begin
          bus.out_data[j*OUT_W +: OUT_W] = v_row[j][OUT_W-1:0];
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_wino_btdb_stream_f23.sv
// Bench for wino_btdb_stream_f23: lossless 20-bit instance driven by a
// scoreboard, plus 8-bit saturating and wrapping instances.
module tb_wino_btdb_stream_f23;
  localparam int DW = 20;
  localparam int OW = 22;
  localparam int SW = 8;

  typedef int tile_t [16];

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wino_btdb_stream_f23_if #(.DATA_WIDTH(DW), .OUT_W(OW)) bus ();
  wino_btdb_stream_f23_if #(.DATA_WIDTH(SW), .OUT_W(SW)) bus_s ();
  wino_btdb_stream_f23_if #(.DATA_WIDTH(SW), .OUT_W(SW)) bus_w ();

  wino_btdb_stream_f23 #(.DATA_WIDTH(DW), .OUT_W(OW), .SAT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  wino_btdb_stream_f23 #(.DATA_WIDTH(SW), .OUT_W(SW), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s));
  wino_btdb_stream_f23 #(.DATA_WIDTH(SW), .OUT_W(SW), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus_w));

  int    n_cmp = 0;
  int    n_err = 0;
  int    exp_q [$];
  tile_t part;
  int    part_n = 0;
  int    n_beats = 0;
  int    sb_row_e;
  int    rows_in = 0;
  bit    in_acc, out_acc, in_vs, rand_data;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: V = B^T * d * B with explicit matrices
  function automatic int bt(input int i, input int k);
    case (i)
      0:       return (k == 0) ? 1 : (k == 2) ? -1 : 0;
      1:       return (k == 1 || k == 2) ? 1 : 0;
      2:       return (k == 1) ? -1 : (k == 2) ? 1 : 0;
      default: return (k == 1) ? 1 : (k == 3) ? -1 : 0;
    endcase
  endfunction

  function automatic int vref(input tile_t d, input int i, input int j);
    int s = 0;
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < 4; l++)
        s += bt(i, k) * d[k*4+l] * bt(j, l);
    return s;
  endfunction

  function automatic int fit8(input int x, input bit sat);
    int w;
    if (sat) begin
      if (x > 127) return 127;
      if (x < -128) return -128;
      return x;
    end
    w = x & 255;
    if (w > 127) w -= 256;
    return w;
  endfunction

  function automatic int rnd_s(input int w);
    int r;
    r = int'($urandom);
    return (r <<< (32 - w)) >>> (32 - w);
  endfunction

  function automatic int get_in(input int j);
    return int'($signed(bus.in_data[j*DW +: DW]));
  endfunction
  function automatic int get_m(input int j);
    return int'($signed(bus.out_data[j*OW +: OW]));
  endfunction
  function automatic int get_s(input int j);
    return int'($signed(bus_s.out_data[j*SW +: SW]));
  endfunction
  function automatic int get_w(input int j);
    return int'($signed(bus_w.out_data[j*SW +: SW]));
  endfunction

  // Input monitor: collect accepted rows, push the expected tile when complete
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready) begin
      for (int j = 0; j < 4; j++) part[part_n*4+j] = get_in(j);
      part_n++;
      if (part_n == 4) begin
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) exp_q.push_back(vref(part, i, j));
          exp_q.push_back(i);
        end
        part_n = 0;
      end
    end
  end

  // Output monitor: every transferred row against the expected queue
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_beats++;
      if (exp_q.size() < 5) begin
        check_eq("sb_unexpected_row", exp_q.size(), 5);
      end else begin
        for (int j = 0; j < 4; j++) check_eq("sb_data", get_m(j), exp_q.pop_front());
        sb_row_e = exp_q.pop_front();
        check_eq("sb_row", bus.out_row, sb_row_e);
        check_eq("sb_last", bus.out_last, (sb_row_e == 3) ? 1 : 0);
      end
    end
  end

  task automatic new_row();
    for (int j = 0; j < 4; j++) begin
      int v;
      case ($urandom_range(3))
        0:       v = (1 << (DW - 1)) - 1;
        1:       v = -(1 << (DW - 1));
        default: v = rnd_s(DW);
      endcase
      bus.in_data[j*DW +: DW] = DW'(v);
    end
  endtask

  // One clock: sample handshakes mid-cycle, return 1 time unit after the edge
  task automatic cyc();
    @(negedge clk);
    in_vs   = bus.in_valid;
    in_acc  = bus.in_valid && bus.in_ready;
    out_acc = bus.out_valid && bus.out_ready;
    @(posedge clk);
    #1;
    if (in_acc) begin
      rows_in++;
      if (rand_data) new_row();
    end
  endtask

  task automatic feed(input int n, input int bud);
    int target = rows_in + n;
    bus.in_valid = 1'b1;
    while (rows_in < target && bud > 0) begin
      cyc();
      bud--;
    end
    bus.in_valid = 1'b0;
    check_eq("feed_done", rows_in, target);
  endtask

  task automatic drain();
    int bud = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0 && bud < 300) begin
      cyc();
      bud++;
    end
    check_eq("drain_done", exp_q.size(), 0);
    bus.out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_out_row", bus.out_row, 0);
    exp_q.delete();
    part_n = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic small_tile(input tile_t st);
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        bus_s.in_data[j*SW +: SW] = SW'(st[r*4+j]);
        bus_w.in_data[j*SW +: SW] = SW'(st[r*4+j]);
      end
      bus_s.in_valid = 1'b1;
      bus_w.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus_s.in_valid = 1'b0;
    bus_w.in_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      check_eq("sat_valid", bus_s.out_valid, 1);
      check_eq("wrap_valid", bus_w.out_valid, 1);
      for (int j = 0; j < 4; j++) begin
        check_eq("sat_data", get_s(j), fit8(vref(st, r, j), 1'b1));
        check_eq("wrap_data", get_w(j), fit8(vref(st, r, j), 1'b0));
      end
      check_eq("sat_row", bus_s.out_row, r);
      bus_s.out_ready = 1'b1;
      bus_w.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_s.out_ready = 1'b0;
      bus_w.out_ready = 1'b0;
    end
    check_eq("sat_empty", bus_s.out_valid, 0);
  endtask

  initial begin
    #600000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tile_t st;
    int    basic_exp [16] = '{0, -16, 0, 0, -4, 34, 2, -4, 0, 8, 0, 0, 0, -16, 0, 0};
    int    first_c, last_c, nout, ndrop, bud, beats0;

    bus.in_valid = 1'b0;   bus.out_ready = 1'b0;   bus.in_data = '0;
    bus_s.in_valid = 1'b0; bus_s.out_ready = 1'b0; bus_s.in_data = '0;
    bus_w.in_valid = 1'b0; bus_w.out_ready = 1'b0; bus_w.in_data = '0;
    rand_data = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset_in_ready", bus.in_ready, 1);
    check_eq("reset_out_valid", bus.out_valid, 0);
    check_eq("reset_out_row", bus.out_row, 0);
    check_eq("reset_out_last", bus.out_last, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Narrow outputs: saturate and wrap on the extreme tile, then random tiles
    for (int r = 0; r < 4; r++) begin
      st[r*4+0] = 127; st[r*4+1] = -128; st[r*4+2] = -128; st[r*4+3] = 127;
    end
    small_tile(st);
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 16; k++) st[k] = rnd_s(SW);
      small_tile(st);
    end

    // Basic tile, drained one row at a time against fixed values
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) bus.in_data[j*DW +: DW] = DW'(r*4 + j + 1);
      bus.in_valid = 1'b1;
      cyc();
      if (r == 2) check_eq("basic_not_yet", bus.out_valid, 0);
    end
    bus.in_valid = 1'b0;
    check_eq("basic_latency", bus.out_valid, 1);
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) check_eq("basic_data", get_m(j), basic_exp[r*4+j]);
      check_eq("basic_row", bus.out_row, r);
      check_eq("basic_last", bus.out_last, (r == 3) ? 1 : 0);
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
    end
    check_eq("basic_empty", bus.out_valid, 0);

    // Full-rate stream: 8 tiles back to back
    rand_data = 1'b1;
    new_row();
    rows_in = 0; first_c = -1; last_c = -1; nout = 0; ndrop = 0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 45; c++) begin
      if (rows_in >= 32) bus.in_valid = 1'b0;
      cyc();
      if (in_vs && !in_acc) ndrop++;
      if (out_acc) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        nout++;
      end
    end
    bus.out_ready = 1'b0;
    check_eq("rate_in_ready_drops", ndrop, 0);
    check_eq("rate_rows_in", rows_in, 32);
    check_eq("rate_first_out_cycle", first_c, 4);
    check_eq("rate_out_beats", nout, 32);
    check_eq("rate_out_span", last_c - first_c, 31);

    // Backpressure: two full banks stall the input
    feed(8, 20);
    check_eq("bp_full_in_ready", bus.in_ready, 0);
    check_eq("bp_full_out_valid", bus.out_valid, 1);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check_eq("bp_one_drain_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    check_eq("bp_three_drain_ready", bus.in_ready, 0);
    cyc();
    check_eq("bp_four_drain_ready", bus.in_ready, 1);
    check_eq("bp_rows_held", rows_in, 40);
    feed(4, 20);
    drain();

    // Reset mid-tile: partial write, then partial drain with both banks full
    feed(2, 10);
    pulse_reset();
    feed(8, 20);
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    bus.out_ready = 1'b0;
    check_eq("pre_rst_out_valid", bus.out_valid, 1);
    check_eq("pre_rst_in_ready", bus.in_ready, 0);
    pulse_reset();
    bus.out_ready = 1'b1;
    feed(3, 10);
    check_eq("post_rst_no_output", bus.out_valid, 0);
    feed(1, 5);
    check_eq("post_rst_latency", bus.out_valid, 1);
    drain();

    // Random handshakes over 1000 tiles
    rows_in = 0;
    bud     = 0;
    beats0  = n_beats;
    while ((rows_in < 4000 || exp_q.size() > 0) && bud < 40000) begin
      bus.in_valid  = (rows_in < 4000) && ($urandom_range(99) < 70);
      bus.out_ready = ($urandom_range(99) < 70);
      cyc();
      bud++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("rand_rows_in", rows_in, 4000);
    check_eq("rand_pending", exp_q.size(), 0);
    check_eq("rand_out_beats", n_beats - beats0, 4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
